// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one downstream val/rdy port among p_nreqs requesters.
// Define RR_PORT_ARBITER_LOCK_EN to hold the grant across multi-beat (in_last=0) bursts.
module rr_port_arbiter #(
  parameter int p_nreqs     = 4,
  parameter int p_nbits     = 32,
  parameter int p_idx_nbits = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_nreqs-1:0]         in_val,
  output logic [p_nreqs-1:0]         in_rdy,
  input  logic [p_nreqs*p_nbits-1:0] in_msg,
  input  logic [p_nreqs-1:0]         in_last,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_nbits-1:0]         out_msg,
  output logic                       out_last,
  output logic [p_idx_nbits-1:0]     grant_idx,
  output logic                       locked
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [p_idx_nbits-1:0] ptr;
  logic [p_idx_nbits-1:0] winner;
  logic [p_idx_nbits-1:0] scan_idx;
  logic [p_idx_nbits-1:0] sel;
  logic                   any_val;
  logic                   is_locked;
  logic                   fire;

  // Modulo increment that also wraps correctly for non-power-of-two counts.
  function automatic logic [p_idx_nbits-1:0] next_idx(input logic [p_idx_nbits-1:0] v);
    return (v == p_idx_nbits'(p_nreqs - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    any_val  = 1'b0;
    winner   = ptr;
    scan_idx = ptr;
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      if (!any_val && in_val[scan_idx]) begin
        winner  = scan_idx;
        any_val = 1'b1;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

`ifdef RR_PORT_ARBITER_LOCK_EN
  logic [0:0]             state;
  logic [p_idx_nbits-1:0] owner;

  assign is_locked = (state == LOCKED);
  assign sel       = is_locked ? owner : (any_val ? winner : ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      state <= IDLE;
      owner <= '0;
    end else if (fire) begin
      if (state == LOCKED) begin
        if (out_last) begin
          ptr   <= next_idx(owner);
          state <= IDLE;
        end
      end else if (out_last) begin
        ptr <= next_idx(winner);
      end else begin
        owner <= winner;
        state <= LOCKED;
      end
    end
  end

  a_owner_range: assert property (@(posedge clk) disable iff (reset)
    (state == LOCKED) |-> (32'(owner) < p_nreqs));
`else
  assign is_locked = 1'b0;
  assign sel       = any_val ? winner : ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= next_idx(winner);
    end
  end
`endif

  // While locked the owner stays selected even through gaps in its in_val.
  always_comb begin
    in_rdy    = '0;
    out_val   = 1'b0;
    out_msg   = '0;
    out_last  = 1'b0;
    grant_idx = '0;
    locked    = 1'b0;
    if (!reset) begin
      grant_idx = sel;
      locked    = is_locked;
      if (is_locked || any_val) begin
        out_val     = in_val[sel];
        out_msg     = in_msg[32'(sel)*p_nbits +: p_nbits];
        out_last    = in_last[sel];
        in_rdy[sel] = out_rdy;
      end
    end
  end

  assign fire = out_val & out_rdy;

  a_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(in_val));

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed self-checking bench for rr_port_arbiter (4-requester main instance, 3-requester wrap instance).
module tb_rr_port_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_val, in_rdy, in_last;
  logic [N*W-1:0]  in_msg;
  logic            out_val, out_rdy, out_last, locked;
  logic [W-1:0]    out_msg;
  logic [IW-1:0]   grant_idx;

  logic            r3;
  logic [2:0]      in_val3, in_rdy3, in_last3;
  logic [3*W-1:0]  in_msg3;
  logic            out_val3, out_rdy3, out_last3, locked3;
  logic [W-1:0]    out_msg3;
  logic [1:0]      grant3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_port_arbiter #(.p_nreqs(N), .p_nbits(W), .p_idx_nbits(IW)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_last(in_last), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_last(out_last), .grant_idx(grant_idx), .locked(locked)
  );

  rr_port_arbiter #(.p_nreqs(3), .p_nbits(W), .p_idx_nbits(2)) dut3 (
    .clk(clk), .reset(r3), .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3),
    .in_last(in_last3), .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3),
    .out_last(out_last3), .grant_idx(grant3), .locked(locked3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_val = '0; in_last = '0; out_rdy = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_val = 4'b1111; in_last = 4'b1111; out_rdy = 1'b1;
    tick; tick;
    checks++;
    if ({in_rdy, out_val, out_msg, out_last, grant_idx, locked} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_rdy=%b out_val=%b out_msg=%h out_last=%b grant=%0d locked=%b, required all 0",
               in_rdy, out_val, out_msg, out_last, grant_idx, locked);
    end
    out_rdy = 1'b0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_rdy;
    in_val = 4'b1111; in_last = 4'b1111; out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = N'(1 << k);
      checks++;
      if (grant_idx !== IW'(k)) begin
        errors++; $display("FAIL rr_grant[%0d]: got %0d, required %0d", k, grant_idx, k);
      end
      checks++;
      if (out_msg !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("FAIL rr_msg[%0d]: got %h, required %h", k, out_msg, 32'hA000_0000 + 32'(k));
      end
      checks++;
      if (in_rdy !== exp_rdy) begin
        errors++; $display("FAIL rr_in_rdy[%0d]: got %b, required %b", k, in_rdy, exp_rdy);
      end
      tick;
    end
    in_val = '0;
    #1;
    checks++;
    if ({out_val, grant_idx, out_msg} !== {1'b0, 2'd0, 32'h0}) begin
      errors++; $display("FAIL rr_ptr_wrap: out_val=%b grant=%0d msg=%h, required 0/0/0", out_val, grant_idx, out_msg);
    end
    tick;
  endtask

  task automatic test_sparse;
    logic [IW-1:0] exp_g [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [N-1:0]  exp_rdy;
    in_val = 4'b0101; in_last = 4'b1111; out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = N'(1 << exp_g[k]);
      checks++;
      if (grant_idx !== exp_g[k]) begin
        errors++; $display("FAIL sparse_grant[%0d]: got %0d, required %0d", k, grant_idx, exp_g[k]);
      end
      checks++;
      if (in_rdy !== exp_rdy) begin
        errors++; $display("FAIL sparse_in_rdy[%0d]: got %b, required %b", k, in_rdy, exp_rdy);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    // ptr is 3 after the sparse sequence, so scan 3,0,1 picks 1.
    in_val = 4'b0110; in_last = 4'b1111; out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({out_val, grant_idx, in_rdy} !== {1'b1, 2'd1, 4'b0000}) begin
        errors++; $display("FAIL stall[%0d]: out_val=%b grant=%0d in_rdy=%b, required 1/1/0000", k, out_val, grant_idx, in_rdy);
      end
      tick;
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if ({grant_idx, in_rdy} !== {2'd1, 4'b0010}) begin
      errors++; $display("FAIL stall_release: grant=%0d in_rdy=%b, required 1/0010", grant_idx, in_rdy);
    end
    tick;
    checks++;
    if ({grant_idx, in_rdy} !== {2'd2, 4'b0100}) begin
      errors++; $display("FAIL after_stall: grant=%0d in_rdy=%b, required 2/0100", grant_idx, in_rdy);
    end
    tick;
    in_val = '0;
    #1;
    checks++;
    if (grant_idx !== 2'd3) begin
      errors++; $display("FAIL after_stall_ptr: got %0d, required 3", grant_idx);
    end
    tick;
  endtask

  task automatic test_wrap3;
    logic [1:0] exp_g [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    r3 = 1'b0; in_val3 = 3'b111; in_last3 = 3'b111; out_rdy3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (grant3 !== exp_g[k] || out_msg3 !== 32'hB000_0000 + 32'(exp_g[k])) begin
        errors++; $display("FAIL wrap3[%0d]: grant=%0d msg=%h, required %0d", k, grant3, out_msg3, exp_g[k]);
      end
      tick;
    end
    out_rdy3 = 1'b0;
  endtask

`ifdef RR_PORT_ARBITER_LOCK_EN
  task automatic test_lock_burst;
    logic [N-1:0] beat_last [3] = '{4'b0000, 4'b0000, 4'b0010};
    do_reset;
    in_val = 4'b0001; in_last = 4'b0001; out_rdy = 1'b1;
    tick;
    in_val = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      in_last = beat_last[k];
      #1;
      checks++;
      if ({grant_idx, locked, in_rdy, out_last} !== {2'd1, (k > 0), 4'b0010, (k == 2)}) begin
        errors++; $display("FAIL burst[%0d]: grant=%0d locked=%b in_rdy=%b last=%b, required 1/%0d/0010/%0d",
                           k, grant_idx, locked, in_rdy, out_last, (k > 0), (k == 2));
      end
      tick;
    end
    in_val = 4'b0101; in_last = '0; out_rdy = 1'b0;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL burst_next2: grant=%0d locked=%b, required 2/0", grant_idx, locked);
    end
    in_val = 4'b0001;
    #1;
    checks++;
    if (grant_idx !== 2'd0) begin
      errors++; $display("FAIL burst_next0: got %0d, required 0", grant_idx);
    end
    tick;
  endtask

  task automatic test_lock_gap;
    do_reset;
    in_val = 4'b0001; in_last = 4'b0001; out_rdy = 1'b1;
    tick;
    in_val = 4'b1010; in_last = 4'b0000;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd1, 1'b0}) begin
      errors++; $display("FAIL gap_first: grant=%0d locked=%b, required 1/0", grant_idx, locked);
    end
    tick;
    in_val = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({out_val, in_rdy[3], locked, grant_idx} !== {1'b0, 1'b0, 1'b1, 2'd1}) begin
        errors++; $display("FAIL gap[%0d]: out_val=%b in_rdy3=%b locked=%b grant=%0d, required 0/0/1/1",
                           k, out_val, in_rdy[3], locked, grant_idx);
      end
      tick;
    end
    in_val = 4'b1010; in_last = 4'b0010;
    #1;
    checks++;
    if ({out_val, grant_idx, out_last, locked} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL gap_resume: out_val=%b grant=%0d last=%b locked=%b, required 1/1/1/1",
                         out_val, grant_idx, out_last, locked);
    end
    tick;
    in_val = 4'b1000; in_last = '0; out_rdy = 1'b0;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL gap_release: grant=%0d locked=%b, required 3/0", grant_idx, locked);
    end
    tick;
  endtask

  task automatic test_reset_locked;
    do_reset;
    in_val = 4'b0100; in_last = 4'b0000; out_rdy = 1'b1;
    tick;
    in_val = 4'b1100; out_rdy = 1'b0;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL pre_reset_lock: grant=%0d locked=%b, required 2/1", grant_idx, locked);
    end
    reset = 1'b1;
    tick;
    checks++;
    if ({out_val, in_rdy, locked, grant_idx} !== '0) begin
      errors++; $display("FAIL reset_in_lock: out_val=%b in_rdy=%b locked=%b grant=%0d, required 0",
                         out_val, in_rdy, locked, grant_idx);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL post_reset: grant=%0d locked=%b, required 2/0", grant_idx, locked);
    end
    in_val = '0;
    #1;
    checks++;
    if (grant_idx !== 2'd0) begin
      errors++; $display("FAIL post_reset_ptr: got %0d, required 0", grant_idx);
    end
    tick;
  endtask
`else
  task automatic test_interleave;
    // ptr is 3 here; beats without in_last still rotate per fire.
    logic [IW-1:0] exp_g [3] = '{2'd0, 2'd1, 2'd0};
    in_val = 4'b0011; in_last = 4'b0000; out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({grant_idx, locked, out_last} !== {exp_g[k], 1'b0, 1'b0}) begin
        errors++; $display("FAIL interleave[%0d]: grant=%0d locked=%b last=%b, required %0d/0/0",
                           k, grant_idx, locked, out_last, exp_g[k]);
      end
      tick;
    end
    in_val = '0;
    #1;
    checks++;
    if (grant_idx !== 2'd1) begin
      errors++; $display("FAIL interleave_ptr: got %0d, required 1", grant_idx);
    end
    tick;
  endtask

  task automatic test_reset_midstream;
    do_reset;
    in_val = 4'b1100;
    #1;
    checks++;
    if ({grant_idx, locked} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL post_reset: grant=%0d locked=%b, required 2/0", grant_idx, locked);
    end
    in_val = '0;
    #1;
    checks++;
    if (grant_idx !== 2'd0) begin
      errors++; $display("FAIL post_reset_ptr: got %0d, required 0", grant_idx);
    end
    tick;
  endtask
`endif

  initial begin
    reset = 1'b1; in_val = '0; in_last = '0; out_rdy = 1'b0;
    r3 = 1'b1; in_val3 = '0; in_last3 = '0; out_rdy3 = 1'b0;
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) in_msg3[i*W +: W] = 32'hB000_0000 + 32'(i);
    #1;
    test_reset;
    test_round_robin;
    test_sparse;
    test_backpressure;
    test_wrap3;
`ifdef RR_PORT_ARBITER_LOCK_EN
    test_lock_burst;
    test_lock_gap;
    test_reset_locked;
`else
    test_interleave;
    test_reset_midstream;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
